spdif_rate_ctrl: RTL and testbench
==================================

Name: spdif_rate_ctrl

Overview:
Rate-scan and lock supervisor for the S/PDIF receiver (spdif_dai). It drives the receiver's clk_per_halfbit and reset, then steps through candidate half-bit periods until the receiver produces valid alternating L/R samples. Once locked it watches for signal loss and re-acquires. It sits between the control and status register block and the receiver instance.

Parameters:
MAX_CLK_PER_HALFBIT_LOG2, 5, width of the clk_per_halfbit_o bus; must match the receiver.
MIN_HALFBIT, 4, first candidate half-bit period in clk cycles; must be ≥2.
MAX_HALFBIT, 16, last candidate; must be ≥ MIN_HALFBIT and ≤ 2^MAX_CLK_PER_HALFBIT_LOG2-1.
TIMER_LOG2, 16, width of the search/watchdog timer.
SEARCH_CYCLES, 40000, dwell time per candidate in cycles; must be ≤ 2^TIMER_LOG2.
LOSS_CYCLES, 4000, cycles without an ack_i in LOCKED before loss is declared; must be ≤ 2^TIMER_LOG2.
LOCK_ACKS, 8, number of qualifying acks required to declare lock; range 1..255.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en_i  in  1  enable scanning; low forces IDLE
dai_ack_i  in  1  receiver sample strobe (1-cycle pulse)
dai_lrck_i  in  1  receiver lrck, sampled only on dai_ack_i
dai_locked_i  in  1  receiver locked status
dai_rst_o  out  1  synchronous reset to the receiver
clk_per_halfbit_o  out  MAX_CLK_PER_HALFBIT_LOG2  candidate period driven to the receiver
rate_valid_o  out  1  high while in LOCKED
scan_wrap_o  out  1  1-cycle pulse when the scan wraps from MAX_HALFBIT to MIN_HALFBIT

Behaviour:
- Reset (rst_n low, async): state IDLE; dai_rst_o=1; clk_per_halfbit_o=MIN_HALFBIT; rate_valid_o=0; scan_wrap_o=0; timer=0; ack count=0; last_lrck=0.
- All outputs are registered. State changes and output updates occur on the clk edge after the triggering input is sampled.
- IDLE: dai_rst_o=1. When en_i=1, go to RST_DAI with the current candidate.
- RST_DAI: dai_rst_o=1 for exactly 2 cycles, then go to SEARCH. On entry, clear timer and ack count; set last_lrck to the inverse of dai_lrck_i.
- SEARCH: dai_rst_o=0; timer increments each cycle.
  - An ack qualifies when dai_ack_i=1 and dai_lrck_i≠last_lrck. A qualifying ack increments the count and loads last_lrck. A non-alternating ack clears the count to 0 and loads last_lrck.
  - When the count reaches LOCK_ACKS, go to LOCKED and set rate_valid_o=1 on the same edge.
  - When timer = SEARCH_CYCLES-1 without lock: advance the candidate to the next value, or to MIN_HALFBIT after MAX_HALFBIT (pulsing scan_wrap_o for 1 cycle). Then go to RST_DAI.
  - If lock and timeout occur on the same cycle, lock wins.
- LOCKED: timer clears on every dai_ack_i and otherwise increments. Loss is declared when timer = LOSS_CYCLES-1, or when dai_locked_i=0, or when an ack arrives with a non-alternating lrck. On loss: rate_valid_o=0 on the same edge, candidate unchanged, go to RST_DAI (retry the same rate first).
- en_i=0 in any state: go to IDLE next edge; rate_valid_o=0; candidate held.
- Candidate arithmetic is unsigned and never leaves [MIN_HALFBIT, MAX_HALFBIT].

Optional Feature:
SPDIF_RATE_CTRL_STATS_EN
- Defined: adds output relock_cnt_o, 8 bits, reset 0. It increments, saturating at 255, on each LOCKED→RST_DAI loss transition. It is cleared when en_i=0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset and enable: hold rst_n=0, then release with en_i=0 → dai_rst_o=1, clk_per_halfbit_o=4. Raise en_i → dai_rst_o=1 for exactly 2 cycles, then 0.
- Lock at 8: model a receiver that produces alternating-lrck acks every 64 cycles only when clk_per_halfbit_o=8 → candidates 4,5,6,7 each time out after 40000 cycles. At 8, rate_valid_o rises on the 8th ack.
- Non-alternating acks: at the correct rate, send lrck pattern 0,1,1,0,… → count restarts and no lock before 8 consecutive alternations. Lock occurs at the 8th alternating ack.
- Wrap: no receiver activity → after candidate 16 times out, scan_wrap_o pulses once and clk_per_halfbit_o=4.
- Loss: in LOCKED stop the acks → after 4000 cycles rate_valid_o=0 and dai_rst_o pulses for 2 cycles with the candidate still 8. Also drop dai_locked_i → same response on the next edge. With STATS_EN, relock_cnt_o=1.
- Async reset mid-SEARCH: assert rst_n=0 asynchronously → outputs return to reset values without waiting for a clk edge. en_i=0 while LOCKED → IDLE, rate_valid_o=0.

Source files
------------

// File: rtl/spdif_rate_ctrl_if.sv
// Receiver-side bundle between the rate supervisor and the S/PDIF receiver.
// master: the rate supervisor (drives period and receiver reset).
// slave : the receiver (drives sample strobe, lrck and lock status).
interface spdif_rate_ctrl_if #(
  parameter int MAX_CLK_PER_HALFBIT_LOG2 = 5
) ();
  logic                                dai_ack_i;
  logic                                dai_lrck_i;
  logic                                dai_locked_i;
  logic                                dai_rst_o;
  logic [MAX_CLK_PER_HALFBIT_LOG2-1:0] clk_per_halfbit_o;

  modport master (
    input  dai_ack_i,
    input  dai_lrck_i,
    input  dai_locked_i,
    output dai_rst_o,
    output clk_per_halfbit_o
  );

  modport slave (
    output dai_ack_i,
    output dai_lrck_i,
    output dai_locked_i,
    input  dai_rst_o,
    input  clk_per_halfbit_o
  );
endinterface

// File: rtl/spdif_rate_ctrl.sv
// Rate-scan and lock supervisor for the S/PDIF receiver.
// Steps the receiver through candidate half-bit periods and holds each one
// until the receiver shows alternating L/R samples. Once locked, it watches
// for signal loss and retries the same rate first.
// Optional build macro: SPDIF_RATE_CTRL_STATS_EN adds relock_cnt_o. This is
// a saturating count of loss-triggered re-acquisitions.
module spdif_rate_ctrl #(
  parameter int MAX_CLK_PER_HALFBIT_LOG2 = 5,
  parameter int MIN_HALFBIT              = 4,
  parameter int MAX_HALFBIT              = 16,
  parameter int TIMER_LOG2               = 16,
  parameter int SEARCH_CYCLES            = 40000,
  parameter int LOSS_CYCLES              = 4000,
  parameter int LOCK_ACKS                = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en_i,
  spdif_rate_ctrl_if.master        dai,
  output logic                     rate_valid_o,
  output logic                     scan_wrap_o
`ifdef SPDIF_RATE_CTRL_STATS_EN
  ,
  output logic [7:0]               relock_cnt_o
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RST_DAI = 2'd1,
    ST_SEARCH  = 2'd2,
    ST_LOCKED  = 2'd3
  } state_e;

  localparam int CW = MAX_CLK_PER_HALFBIT_LOG2;
  localparam int TW = TIMER_LOG2;

  localparam logic [CW-1:0] CAND_MIN    = CW'(MIN_HALFBIT);
  localparam logic [CW-1:0] CAND_MAX    = CW'(MAX_HALFBIT);
  localparam logic [TW-1:0] SEARCH_LAST = TW'(SEARCH_CYCLES - 1);
  localparam logic [TW-1:0] LOSS_LAST   = TW'(LOSS_CYCLES - 1);
  localparam logic [TW-1:0] RST_LAST    = TW'(1);
  localparam logic [7:0]    LOCK_LAST   = 8'(LOCK_ACKS - 1);

  state_e          state_r;
  logic [TW-1:0]   timer_r;
  logic [7:0]      ack_cnt_r;
  logic            last_lrck_r;
  logic [CW-1:0]   cand_r;
  logic            dai_rst_r;
  logic            rate_valid_r;
  logic            scan_wrap_r;

  logic            qual_ack_s;
  logic            bad_ack_s;
  logic [CW-1:0]   next_cand_s;
  logic            wrap_s;
  logic            loss_s;

  // An ack is qualifying only if lrck flipped since the previous ack.
  always_comb begin
    qual_ack_s = 1'b0;
    bad_ack_s  = 1'b0;
    if (dai.dai_ack_i) begin
      qual_ack_s = (dai.dai_lrck_i != last_lrck_r);
      bad_ack_s  = (dai.dai_lrck_i == last_lrck_r);
    end else begin
      qual_ack_s = 1'b0;
      bad_ack_s  = 1'b0;
    end
  end

  // Next scan candidate. It wraps back to the minimum, and the >= keeps it in range.
  always_comb begin
    next_cand_s = CAND_MIN;
    wrap_s      = 1'b0;
    if (cand_r >= CAND_MAX) begin
      next_cand_s = CAND_MIN;
      wrap_s      = 1'b1;
    end else begin
      next_cand_s = cand_r + CW'(1);
      wrap_s      = 1'b0;
    end
  end

  // Loss of lock: no ack for too long, receiver unlocked, or lrck stopped alternating.
  always_comb begin
    loss_s = 1'b0;
    if (en_i && (state_r == ST_LOCKED)) begin
      loss_s = !dai.dai_locked_i || bad_ack_s || (timer_r == LOSS_LAST);
    end else begin
      loss_s = 1'b0;
    end
  end

  // Supervisor FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      timer_r      <= '0;
      ack_cnt_r    <= 8'd0;
      last_lrck_r  <= 1'b0;
      cand_r       <= CAND_MIN;
      dai_rst_r    <= 1'b1;
      rate_valid_r <= 1'b0;
      scan_wrap_r  <= 1'b0;
    end else begin
      scan_wrap_r <= 1'b0;
      if (!en_i) begin
        state_r      <= ST_IDLE;
        timer_r      <= '0;
        ack_cnt_r    <= 8'd0;
        dai_rst_r    <= 1'b1;
        rate_valid_r <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            state_r     <= ST_RST_DAI;
            dai_rst_r   <= 1'b1;
            timer_r     <= '0;
            ack_cnt_r   <= 8'd0;
            last_lrck_r <= ~dai.dai_lrck_i;
          end
          ST_RST_DAI: begin
            // The timer doubles as the two-cycle receiver reset counter.
            if (timer_r == RST_LAST) begin
              state_r   <= ST_SEARCH;
              dai_rst_r <= 1'b0;
              timer_r   <= '0;
            end else begin
              timer_r <= timer_r + TW'(1);
            end
          end
          ST_SEARCH: begin
            if (qual_ack_s && (ack_cnt_r == LOCK_LAST)) begin
              // Lock has priority over a simultaneous dwell timeout.
              state_r      <= ST_LOCKED;
              rate_valid_r <= 1'b1;
              timer_r      <= '0;
              ack_cnt_r    <= ack_cnt_r + 8'd1;
              last_lrck_r  <= dai.dai_lrck_i;
            end else if (timer_r == SEARCH_LAST) begin
              state_r     <= ST_RST_DAI;
              cand_r      <= next_cand_s;
              scan_wrap_r <= wrap_s;
              dai_rst_r   <= 1'b1;
              timer_r     <= '0;
              ack_cnt_r   <= 8'd0;
              last_lrck_r <= ~dai.dai_lrck_i;
            end else begin
              timer_r <= timer_r + TW'(1);
              if (qual_ack_s) begin
                ack_cnt_r   <= ack_cnt_r + 8'd1;
                last_lrck_r <= dai.dai_lrck_i;
              end else if (bad_ack_s) begin
                ack_cnt_r   <= 8'd0;
                last_lrck_r <= dai.dai_lrck_i;
              end else begin
                ack_cnt_r <= ack_cnt_r;
              end
            end
          end
          ST_LOCKED: begin
            if (loss_s) begin
              // Keep the candidate so the same rate is retried first.
              state_r      <= ST_RST_DAI;
              rate_valid_r <= 1'b0;
              dai_rst_r    <= 1'b1;
              timer_r      <= '0;
              ack_cnt_r    <= 8'd0;
              last_lrck_r  <= ~dai.dai_lrck_i;
            end else if (dai.dai_ack_i) begin
              timer_r     <= '0;
              last_lrck_r <= dai.dai_lrck_i;
            end else begin
              timer_r <= timer_r + TW'(1);
            end
          end
          default: begin
            state_r      <= ST_IDLE;
            dai_rst_r    <= 1'b1;
            rate_valid_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign dai.dai_rst_o         = dai_rst_r;
  assign dai.clk_per_halfbit_o = cand_r;
  assign rate_valid_o          = rate_valid_r;
  assign scan_wrap_o           = scan_wrap_r;

`ifdef SPDIF_RATE_CTRL_STATS_EN
  logic [7:0] relock_cnt_r;

  // Saturating count of loss-triggered re-acquisitions. It is cleared while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      relock_cnt_r <= 8'd0;
    end else if (!en_i) begin
      relock_cnt_r <= 8'd0;
    end else if (loss_s && (relock_cnt_r != 8'd255)) begin
      relock_cnt_r <= relock_cnt_r + 8'd1;
    end else begin
      relock_cnt_r <= relock_cnt_r;
    end
  end

  assign relock_cnt_o = relock_cnt_r;
`endif

endmodule

// File: tb/tb_spdif_rate_ctrl.sv
// Directed bench for spdif_rate_ctrl. Dwell and loss times are shortened
// (SEARCH_CYCLES=1000, LOSS_CYCLES=300) so that a full scan stays short.
module tb_spdif_rate_ctrl;
  localparam int SEARCH = 1000;
  localparam int LOSS   = 300;

  logic clk;
  logic rst_n;
  logic en_i;
  logic rate_valid_o;
  logic scan_wrap_o;
`ifdef SPDIF_RATE_CTRL_STATS_EN
  logic [7:0] relock_cnt_o;
`endif

  int compared;
  int mismatched;

  spdif_rate_ctrl_if #(.MAX_CLK_PER_HALFBIT_LOG2(5)) bus ();

  spdif_rate_ctrl #(
    .MAX_CLK_PER_HALFBIT_LOG2(5),
    .MIN_HALFBIT(4),
    .MAX_HALFBIT(16),
    .TIMER_LOG2(16),
    .SEARCH_CYCLES(SEARCH),
    .LOSS_CYCLES(LOSS),
    .LOCK_ACKS(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en_i(en_i),
    .dai(bus.master),
    .rate_valid_o(rate_valid_o),
    .scan_wrap_o(scan_wrap_o)
`ifdef SPDIF_RATE_CTRL_STATS_EN
    ,
    .relock_cnt_o(relock_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Drive a one-cycle ack with the given lrck. The task returns at the next falling edge.
  task automatic ack(input logic lr);
    bus.dai_lrck_i = lr;
    bus.dai_ack_i  = 1'b1;
    @(negedge clk);
    bus.dai_ack_i  = 1'b0;
  endtask

  // Wait, with a bound, until the DUT is searching with the given candidate.
  task automatic wait_run(input int cand, input int bound, input string tag);
    int n;
    n = 0;
    while (!((bus.clk_per_halfbit_o == 5'(cand)) && (bus.dai_rst_o == 1'b0)) && (n < bound)) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n < bound), 32'd1);
  endtask

  initial begin
    logic [10:0] pat1;
    logic [7:0]  pat2;
    logic [7:0]  pat3;
    int          n;
    compared   = 0;
    mismatched = 0;
    rst_n = 1'b0;
    en_i  = 1'b0;
    bus.dai_ack_i    = 1'b0;
    bus.dai_lrck_i   = 1'b0;
    bus.dai_locked_i = 1'b1;

    // Reset state
    cycles(3);
    check("rst_dai_rst", 32'(bus.dai_rst_o), 32'd1);
    check("rst_cand", 32'(bus.clk_per_halfbit_o), 32'd4);
    check("rst_valid", 32'(rate_valid_o), 32'd0);
    check("rst_wrap", 32'(scan_wrap_o), 32'd0);
    rst_n = 1'b1;
    cycles(2);
    check("idle_dai_rst", 32'(bus.dai_rst_o), 32'd1);
    check("idle_cand", 32'(bus.clk_per_halfbit_o), 32'd4);

    // Enable: receiver reset held for exactly two cycles
    en_i = 1'b1;
    cycles(1);
    check("en_rst_c1", 32'(bus.dai_rst_o), 32'd1);
    cycles(1);
    check("en_rst_c2", 32'(bus.dai_rst_o), 32'd1);
    cycles(1);
    check("en_rst_c3", 32'(bus.dai_rst_o), 32'd0);
    check("search_cand4", 32'(bus.clk_per_halfbit_o), 32'd4);

    // The dwell lasts exactly SEARCH cycles
    cycles(SEARCH - 1);
    check("dwell_last_cand", 32'(bus.clk_per_halfbit_o), 32'd4);
    check("dwell_last_rst", 32'(bus.dai_rst_o), 32'd0);
    cycles(1);
    check("dwell_next_cand", 32'(bus.clk_per_halfbit_o), 32'd5);
    check("dwell_next_rst", 32'(bus.dai_rst_o), 32'd1);
    check("dwell_no_wrap", 32'(scan_wrap_o), 32'd0);

    // Scan up to 8, then a non-alternating ack restarts the count
    wait_run(8, 5000, "reach_cand8");
    check("cand8_valid0", 32'(rate_valid_o), 32'd0);
    // lrck sequence 0,1,1 then 0,1,0,1,0,1,0,1 (index 10 sent first)
    pat1 = 11'b01_1010_1010_1;
    pat1 = {1'b0, 1'b1, 1'b1, 8'b0101_0101};
    for (int i = 10; i >= 0; i--) begin
      cycles(63);
      ack(pat1[i]);
      if (i == 1) check("no_lock_7th_alt", 32'(rate_valid_o), 32'd0);
    end
    check("lock_8th_alt", 32'(rate_valid_o), 32'd1);
    check("lock_cand", 32'(bus.clk_per_halfbit_o), 32'd8);

    // Loss by ack timeout
    cycles(LOSS - 1);
    check("loss_pre_valid", 32'(rate_valid_o), 32'd1);
    check("loss_pre_rst", 32'(bus.dai_rst_o), 32'd0);
    cycles(1);
    check("loss_valid", 32'(rate_valid_o), 32'd0);
    check("loss_rst_c1", 32'(bus.dai_rst_o), 32'd1);
    check("loss_cand", 32'(bus.clk_per_halfbit_o), 32'd8);
    cycles(1);
    check("loss_rst_c2", 32'(bus.dai_rst_o), 32'd1);
    cycles(1);
    check("loss_rst_c3", 32'(bus.dai_rst_o), 32'd0);
    check("loss_retry_cand", 32'(bus.clk_per_halfbit_o), 32'd8);
`ifdef SPDIF_RATE_CTRL_STATS_EN
    check("relock_cnt_1", 32'(relock_cnt_o), 32'd1);
`endif

    // Relock, then loss through dai_locked_i dropping
    pat2 = 8'b1010_1010;
    for (int i = 7; i >= 0; i--) begin
      cycles(63);
      ack(pat2[i]);
    end
    check("relock_valid", 32'(rate_valid_o), 32'd1);
    bus.dai_locked_i = 1'b0;
    cycles(1);
    bus.dai_locked_i = 1'b1;
    check("unlock_valid", 32'(rate_valid_o), 32'd0);
    check("unlock_rst", 32'(bus.dai_rst_o), 32'd1);
    check("unlock_cand", 32'(bus.clk_per_halfbit_o), 32'd8);
`ifdef SPDIF_RATE_CTRL_STATS_EN
    check("relock_cnt_2", 32'(relock_cnt_o), 32'd2);
`endif

    // Lock again, then en_i=0 while locked
    wait_run(8, 10, "retry_search");
    pat3 = 8'b0101_0101;
    for (int i = 7; i >= 0; i--) begin
      cycles(63);
      ack(pat3[i]);
    end
    check("lock3_valid", 32'(rate_valid_o), 32'd1);
    en_i = 1'b0;
    cycles(1);
    check("dis_valid", 32'(rate_valid_o), 32'd0);
    check("dis_rst", 32'(bus.dai_rst_o), 32'd1);
    check("dis_cand", 32'(bus.clk_per_halfbit_o), 32'd8);
`ifdef SPDIF_RATE_CTRL_STATS_EN
    check("relock_cnt_clr", 32'(relock_cnt_o), 32'd0);
`endif
    cycles(3);
    check("dis_hold_rst", 32'(bus.dai_rst_o), 32'd1);

    // Wrap from 16 to 4 with no receiver activity
    en_i = 1'b1;
    wait_run(16, 12000, "reach_cand16");
    n = 0;
    while ((bus.clk_per_halfbit_o == 5'd16) && (n < 2000)) begin
      @(negedge clk);
      n++;
    end
    check("wrap_timeout", 32'(n < 2000), 32'd1);
    check("wrap_pulse", 32'(scan_wrap_o), 32'd1);
    check("wrap_cand", 32'(bus.clk_per_halfbit_o), 32'd4);
    cycles(1);
    check("wrap_pulse_end", 32'(scan_wrap_o), 32'd0);

    // Asynchronous reset in the middle of a search
    wait_run(5, 3000, "reach_cand5");
    cycles(3);
    #1 rst_n = 1'b0;
    #1;
    check("async_cand", 32'(bus.clk_per_halfbit_o), 32'd4);
    check("async_rst", 32'(bus.dai_rst_o), 32'd1);
    check("async_valid", 32'(rate_valid_o), 32'd0);
    cycles(2);
    rst_n = 1'b1;
    cycles(2);
    check("post_async_rst", 32'(bus.dai_rst_o), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
